axi4lite_reg_slave: RTL and testbench

AXI4LITE_REG_SLAVE -- requirements
Module: axi4lite_reg_slave

---
 rtl/axi4lite_reg_pkg.sv | 49 ++++
 rtl/axi4lite_wr_chan.sv | 115 +++++++++++
 rtl/axi4lite_reg_slave.sv | 149 ++++++++++++++
 tb/tb_axi4lite_reg_slave.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_reg_pkg.sv
// -----------------------------------------------------------------------------
// axi4lite_reg_pkg
// Shared constants, types and helpers for the four-register AXI4-Lite slave.
//   RESP_OKAY      : response code for every B and R beat
//   NUM_REGS       : number of 32-bit registers behind the slave
//   reg_idx_t      : register index taken from address bits [3:2]
//   wbeat_t        : one buffered write-data beat (data + byte strobes)
//   apply_wstrb()  : byte-lane merge of new data into an old register value
//   idx_onehot()   : one-hot decode of a register index
// -----------------------------------------------------------------------------
package axi4lite_reg_pkg;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam int NUM_REGS  = 4;
    localparam int REG_IDX_W = 2;
    localparam int DATA_W    = 32;
    localparam int STRB_W    = DATA_W / 8;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } wbeat_t;

    function automatic logic [DATA_W-1:0] apply_wstrb(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [NUM_REGS-1:0] idx_onehot(input reg_idx_t idx);
        logic [NUM_REGS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/axi4lite_wr_chan.sv
// -----------------------------------------------------------------------------
// axi4lite_wr_chan
// Write side of the AXI4-Lite register slave: one-entry AW and W holding
// buffers, the commit decision, and the B response channel. The register
// array itself lives in the top; this block only tells it when, where and
// what to write.
//   clk_sys_i, rst_b_i       : clock, async active-low reset
//   en_i                     : low until the first edge after reset release
//   awaddr_i/awvalid_i/awready_o
//   wbeat_i/wvalid_i/wready_o
//   bresp_o/bvalid_o/bready_i
//   commit_o                 : register update happens on this edge
//   commit_idx_o/commit_beat_o : target register and data/strobes to apply
// -----------------------------------------------------------------------------
module axi4lite_wr_chan
    import axi4lite_reg_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk_sys_i,
    input  logic              rst_b_i,
    input  logic              en_i,

    input  logic [ADDR_W-1:0] awaddr_i,
    input  logic              awvalid_i,
    output logic              awready_o,

    input  wbeat_t            wbeat_i,
    input  logic              wvalid_i,
    output logic              wready_o,

    output logic [1:0]        bresp_o,
    output logic              bvalid_o,
    input  logic              bready_i,

    output logic              commit_o,
    output reg_idx_t          commit_idx_o,
    output wbeat_t            commit_beat_o
);

    logic     aw_full_q, aw_full_d;
    reg_idx_t aw_idx_q,  aw_idx_d;
    logic     w_full_q,  w_full_d;
    wbeat_t   w_beat_q,  w_beat_d;
    logic     bvalid_q,  bvalid_d;

    logic aw_hs;
    logic w_hs;
    logic commit;

    // Low address bits select a byte within a word and are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^awaddr_i;

    assign awready_o = en_i & ~aw_full_q;
    assign wready_o  = en_i & ~w_full_q;

    assign aw_hs = awvalid_i & awready_o;
    assign w_hs  = wvalid_i  & wready_o;

    // A held response blocks the next commit so B beats never overlap.
    assign commit = aw_full_q & w_full_q & ~bvalid_q;

    always_comb begin
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        w_full_d  = w_full_q;
        w_beat_d  = w_beat_q;
        bvalid_d  = bvalid_q;

        // Commit needs both buffers full, which keeps both READYs low,
        // so a commit and a new handshake never land on the same edge.
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end
        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = awaddr_i[3:2];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_beat_d = wbeat_i;
        end

        if (commit) begin
            bvalid_d = 1'b1;
        end else if (bvalid_q && bready_i) begin
            bvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            w_beat_q  <= '0;
            bvalid_q  <= 1'b0;
        end else begin
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            w_full_q  <= w_full_d;
            w_beat_q  <= w_beat_d;
            bvalid_q  <= bvalid_d;
        end
    end

    assign bvalid_o      = bvalid_q;
    assign bresp_o       = RESP_OKAY;
    assign commit_o      = commit;
    assign commit_idx_o  = aw_idx_q;
    assign commit_beat_o = w_beat_q;

endmodule

// File: rtl/axi4lite_reg_slave.sv
// -----------------------------------------------------------------------------
// axi4lite_reg_slave
// AXI4-Lite slave exposing four 32-bit read/write registers to user logic.
// Write buffering and the B channel sit in axi4lite_wr_chan; the register
// array, the read channel and the write-strobe pulses live here.
//   S_AXI_ACLK / S_AXI_ARESETN : clock, async active-low reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B* : write address, data, response
//   S_AXI_AR* / S_AXI_R*            : read address, data
//   reg0_o..reg3_o : live register contents
//   wr_pulse_o     : one-hot, high for the cycle after a register is written
// -----------------------------------------------------------------------------
module axi4lite_reg_slave
    import axi4lite_reg_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,

    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,

    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,

    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,

    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
    output logic [NUM_REGS-1:0]             wr_pulse_o
);

    // READY outputs must stay low during reset and rise on the first edge
    // after release, so they are gated by this flag rather than driven
    // straight from the buffer/valid state.
    logic en_q;

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]             wr_pulse_q, wr_pulse_d;
    logic [DATA_W-1:0]               rdata_q, rdata_d;
    logic                            rvalid_q, rvalid_d;

    logic     commit;
    reg_idx_t commit_idx;
    wbeat_t   commit_beat;
    wbeat_t   wbeat_in;

    reg_idx_t ar_idx;
    logic     ar_hs;

    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR};

    assign wbeat_in = '{data: S_AXI_WDATA, strb: S_AXI_WSTRB};

    axi4lite_wr_chan #(
        .ADDR_W (C_S_AXI_ADDR_WIDTH)
    ) u_wr_chan (
        .clk_sys_i     (S_AXI_ACLK),
        .rst_b_i       (S_AXI_ARESETN),
        .en_i          (en_q),
        .awaddr_i      (S_AXI_AWADDR),
        .awvalid_i     (S_AXI_AWVALID),
        .awready_o     (S_AXI_AWREADY),
        .wbeat_i       (wbeat_in),
        .wvalid_i      (S_AXI_WVALID),
        .wready_o      (S_AXI_WREADY),
        .bresp_o       (S_AXI_BRESP),
        .bvalid_o      (S_AXI_BVALID),
        .bready_i      (S_AXI_BREADY),
        .commit_o      (commit),
        .commit_idx_o  (commit_idx),
        .commit_beat_o (commit_beat)
    );

    assign ar_idx        = S_AXI_ARADDR[3:2];
    assign S_AXI_ARREADY = en_q & ~rvalid_q;
    assign ar_hs         = S_AXI_ARVALID & S_AXI_ARREADY;

    always_comb begin
        regs_d     = regs_q;
        wr_pulse_d = '0;
        rdata_d    = rdata_q;
        rvalid_d   = rvalid_q;

        if (commit) begin
            regs_d[commit_idx] = apply_wstrb(regs_q[commit_idx],
                                             commit_beat.data,
                                             commit_beat.strb);
            // Pulses even with an all-zero strobe: the write still happened.
            wr_pulse_d = idx_onehot(commit_idx);
        end

        // Sampling regs_q (not regs_d) gives a read that coincides with a
        // commit to the same register the pre-write value.
        if (ar_hs) begin
            rdata_d  = regs_q[ar_idx];
            rvalid_d = 1'b1;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            en_q       <= 1'b0;
            regs_q     <= '0;
            wr_pulse_q <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            en_q       <= 1'b1;
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign S_AXI_RDATA  = rdata_q;
    assign S_AXI_RRESP  = RESP_OKAY;
    assign S_AXI_RVALID = rvalid_q;

    assign reg0_o     = regs_q[0];
    assign reg1_o     = regs_q[1];
    assign reg2_o     = regs_q[2];
    assign reg3_o     = regs_q[3];
    assign wr_pulse_o = wr_pulse_q;

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
module tb_axi4lite_reg_slave;

    logic        clk;
    logic        rst_n;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] reg0, reg1, reg2, reg3;
    logic [3:0]  wr_pulse;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] model [4];
    logic [31:0] exp_q [$];
    logic [31:0] dut_regs [4];

    assign dut_regs[0] = reg0;
    assign dut_regs[1] = reg1;
    assign dut_regs[2] = reg2;
    assign dut_regs[3] = reg3;

    axi4lite_reg_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .reg0_o        (reg0),
        .reg1_o        (reg1),
        .reg2_o        (reg2),
        .reg3_o        (reg3),
        .wr_pulse_o    (wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bus driving helpers (no checking beyond timeouts) -----

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        logic aw_done, w_done, aw_hs, w_hs;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        aw_done = 1'b0; w_done = 1'b0;
        for (int c = 0; c < 50 && !(aw_done && w_done); c++) begin
            @(negedge clk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin wvalid  = 1'b0; w_done  = 1'b1; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!(aw_done && w_done)) begin
            n_cmp++; n_err++;
            $display("FAIL write_handshake_timeout addr=%h aw_done=%0b w_done=%0b required both 1",
                     addr, aw_done, w_done);
        end
    endtask

    task automatic wait_b(output logic [1:0] resp);
        logic got;
        got = 1'b0;
        resp = 2'bxx;
        bready = 1'b1;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (bvalid) begin resp = bresp; got = 1'b1; end
            @(posedge clk); #1;
        end
        bready = 1'b0;
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL b_timeout bvalid never seen, required within 50 cycles");
        end
    endtask

    task automatic do_read(input logic [3:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
        logic done, got;
        araddr = addr; arvalid = 1'b1; done = 1'b0; got = 1'b0;
        data = 'x; resp = 'x;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (arready) done = 1'b1;
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
        rready = 1'b1;
        for (int c = 0; c < 50 && !got && done; c++) begin
            @(negedge clk);
            if (rvalid) begin data = rdata; resp = rresp; got = 1'b1; end
            @(posedge clk); #1;
        end
        rready = 1'b0;
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL read_timeout addr=%h ar_done=%0b r_seen=%0b required both 1",
                     addr, done, got);
        end
    endtask

    // ---------------- scenarios ---------------------------------------------

    task automatic test_reset;
        rst_n = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = '0;
        #12;
        n_cmp++; if ({awready, wready, arready} !== 3'b000) begin n_err++;
            $display("FAIL reset_readys got %b expected 000", {awready, wready, arready}); end
        n_cmp++; if ({bvalid, rvalid} !== 2'b00) begin n_err++;
            $display("FAIL reset_valids got %b expected 00", {bvalid, rvalid}); end
        n_cmp++; if (rdata !== 32'h0) begin n_err++;
            $display("FAIL reset_rdata got %h expected 0", rdata); end
        n_cmp++; if (wr_pulse !== 4'b0) begin n_err++;
            $display("FAIL reset_wr_pulse got %b expected 0000", wr_pulse); end
        n_cmp++; if ({reg0, reg1, reg2, reg3} !== 128'h0) begin n_err++;
            $display("FAIL reset_regs got %h %h %h %h expected 0", reg0, reg1, reg2, reg3); end
        @(negedge clk); rst_n = 1'b1; #1;
        n_cmp++; if (awready !== 1'b0) begin n_err++;
            $display("FAIL ready_before_edge awready got %b expected 0", awready); end
        @(posedge clk); #1;
        n_cmp++; if ({awready, wready, arready} !== 3'b111) begin n_err++;
            $display("FAIL ready_after_edge got %b expected 111", {awready, wready, arready}); end
    endtask

    task automatic test_basic_rw;
        logic [1:0] r;
        logic [31:0] d, e;
        for (int i = 0; i < 4; i++) begin
            axi_write(4'(i * 4), 32'(i + 1), 4'hF);
            model[i] = 32'(i + 1);
            wait_b(r);
            n_cmp++; if (r !== 2'b00) begin n_err++;
                $display("FAIL basic_bresp reg%0d got %b expected 00", i, r); end
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(model[i]);
            do_read(4'(i * 4), d, r);
            e = exp_q.pop_front();
            n_cmp++; if (d !== e) begin n_err++;
                $display("FAIL basic_rdata reg%0d got %h expected %h", i, d, e); end
            n_cmp++; if (r !== 2'b00) begin n_err++;
                $display("FAIL basic_rresp reg%0d got %b expected 00", i, r); end
            n_cmp++; if (dut_regs[i] !== model[i]) begin n_err++;
                $display("FAIL basic_reg_o reg%0d got %h expected %h", i, dut_regs[i], model[i]); end
        end
    endtask

    task automatic test_w_before_aw;
        logic [1:0] r;
        wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        n_cmp++; if (wready !== 1'b0) begin n_err++;
            $display("FAIL wfirst_wready_drop got %b expected 0", wready); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bvalid !== 1'b0) begin n_err++;
            $display("FAIL wfirst_no_commit bvalid got %b expected 0", bvalid); end
        awaddr = 4'h8; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        n_cmp++; if (bvalid !== 1'b0) begin n_err++;
            $display("FAIL wfirst_bvalid_early got %b expected 0", bvalid); end
        @(posedge clk); #1;
        model[2] = 32'hA5A5A5A5;
        n_cmp++; if (bvalid !== 1'b1) begin n_err++;
            $display("FAIL wfirst_bvalid got %b expected 1", bvalid); end
        n_cmp++; if (reg2 !== model[2]) begin n_err++;
            $display("FAIL wfirst_reg2 got %h expected %h", reg2, model[2]); end
        n_cmp++; if (wr_pulse !== 4'b0100) begin n_err++;
            $display("FAIL wfirst_wr_pulse got %b expected 0100", wr_pulse); end
        wait_b(r);
    endtask

    task automatic test_wstrb;
        logic [1:0] r;
        axi_write(4'h4, 32'h11223344, 4'hF);
        wait_b(r);
        axi_write(4'h4, 32'hFFFFFFFF, 4'b0101);
        @(posedge clk); #1;
        model[1] = 32'h11FF33FF;
        n_cmp++; if (reg1 !== model[1]) begin n_err++;
            $display("FAIL wstrb_reg1 got %h expected %h", reg1, model[1]); end
        n_cmp++; if (wr_pulse !== 4'b0010) begin n_err++;
            $display("FAIL wstrb_pulse got %b expected 0010", wr_pulse); end
        @(posedge clk); #1;
        n_cmp++; if (wr_pulse !== 4'b0000) begin n_err++;
            $display("FAIL wstrb_pulse_width got %b expected 0000", wr_pulse); end
        wait_b(r);
    endtask

    task automatic test_wstrb_zero;
        logic [1:0] r;
        axi_write(4'hC, 32'hDEADBEEF, 4'b0000);
        @(posedge clk); #1;
        n_cmp++; if (wr_pulse !== 4'b1000) begin n_err++;
            $display("FAIL zstrb_pulse got %b expected 1000", wr_pulse); end
        n_cmp++; if (reg3 !== model[3]) begin n_err++;
            $display("FAIL zstrb_reg3 got %h expected %h", reg3, model[3]); end
        wait_b(r);
        n_cmp++; if (r !== 2'b00) begin n_err++;
            $display("FAIL zstrb_bresp got %b expected 00", r); end
    endtask

    task automatic test_bready_stall;
        logic [1:0] r;
        bready = 1'b0;
        axi_write(4'h0, 32'hCAFE0001, 4'hF);
        @(posedge clk); #1;
        model[0] = 32'hCAFE0001;
        n_cmp++; if (bvalid !== 1'b1 || reg0 !== model[0]) begin n_err++;
            $display("FAIL stall_first_commit bvalid=%b reg0=%h expected 1 %h", bvalid, reg0, model[0]); end
        axi_write(4'h0, 32'hCAFE0002, 4'hF);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            n_cmp++; if (bvalid !== 1'b1 || reg0 !== model[0]) begin n_err++;
                $display("FAIL stall_hold cycle%0d bvalid=%b reg0=%h expected 1 %h", k, bvalid, reg0, model[0]); end
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        n_cmp++; if (bvalid !== 1'b0 || reg0 !== model[0]) begin n_err++;
            $display("FAIL stall_after_b bvalid=%b reg0=%h expected 0 %h", bvalid, reg0, model[0]); end
        @(posedge clk); #1;
        model[0] = 32'hCAFE0002;
        n_cmp++; if (bvalid !== 1'b1 || reg0 !== model[0]) begin n_err++;
            $display("FAIL stall_second_commit bvalid=%b reg0=%h expected 1 %h", bvalid, reg0, model[0]); end
        wait_b(r);
    endtask

    task automatic test_rready_stall;
        logic [31:0] d, e;
        araddr = 4'h5; arvalid = 1'b1;
        exp_q.push_back(model[1]);
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (rvalid !== 1'b1 || rdata !== exp_q[0] || arready !== 1'b0) begin n_err++;
                $display("FAIL rstall_hold cycle%0d rvalid=%b rdata=%h arready=%b expected 1 %h 0",
                         k, rvalid, rdata, arready, exp_q[0]); end
            @(posedge clk); #1;
        end
        rready = 1'b1;
        @(negedge clk);
        d = rdata;
        @(posedge clk); #1;
        rready = 1'b0;
        e = exp_q.pop_front();
        n_cmp++; if (d !== e) begin n_err++;
            $display("FAIL rstall_rdata got %h expected %h", d, e); end
        n_cmp++; if (rvalid !== 1'b0 || arready !== 1'b1) begin n_err++;
            $display("FAIL rstall_release rvalid=%b arready=%b expected 0 1", rvalid, arready); end
    endtask

    task automatic test_concurrent;
        logic [1:0] r;
        logic [31:0] e;
        logic rdy;
        awaddr = 4'h8; wdata = 32'h5A5A0000; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        rdy = awready & wready;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n_cmp++; if (rdy !== 1'b1) begin n_err++;
            $display("FAIL conc_wr_ready got %b expected 1", rdy); end
        araddr = 4'h8; arvalid = 1'b1;
        exp_q.push_back(model[2]);
        model[2] = 32'h5A5A0000;
        @(posedge clk); #1;
        arvalid = 1'b0;
        e = exp_q.pop_front();
        n_cmp++; if (rvalid !== 1'b1 || rdata !== e) begin n_err++;
            $display("FAIL conc_old_value rvalid=%b rdata=%h expected 1 %h", rvalid, rdata, e); end
        n_cmp++; if (bvalid !== 1'b1 || reg2 !== model[2]) begin n_err++;
            $display("FAIL conc_commit bvalid=%b reg2=%h expected 1 %h", bvalid, reg2, model[2]); end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        wait_b(r);
    endtask

    task automatic test_reset_mid;
        logic [1:0] r;
        logic [31:0] d, e;
        bready = 1'b0;
        axi_write(4'hC, 32'h00000077, 4'hF);
        @(posedge clk); #1;
        n_cmp++; if (bvalid !== 1'b1) begin n_err++;
            $display("FAIL rstmid_setup bvalid got %b expected 1", bvalid); end
        awaddr = 4'h4; wdata = 32'h12345678; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) model[i] = '0;
        n_cmp++; if (bvalid !== 1'b0 || wr_pulse !== 4'b0 || awready !== 1'b0) begin n_err++;
            $display("FAIL rstmid_async bvalid=%b wr_pulse=%b awready=%b expected 0 0000 0",
                     bvalid, wr_pulse, awready); end
        n_cmp++; if ({reg0, reg1, reg2, reg3} !== 128'h0) begin n_err++;
            $display("FAIL rstmid_regs got %h %h %h %h expected 0", reg0, reg1, reg2, reg3); end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bvalid !== 1'b0 || reg1 !== 32'h0) begin n_err++;
            $display("FAIL rstmid_discard bvalid=%b reg1=%h expected 0 0", bvalid, reg1); end
        exp_q.push_back(model[1]);
        do_read(4'h4, d, r);
        e = exp_q.pop_front();
        n_cmp++; if (d !== e) begin n_err++;
            $display("FAIL rstmid_readback got %h expected %h", d, e); end
    endtask

    initial begin
        test_reset();
        test_basic_rw();
        test_w_before_aw();
        test_wstrb();
        test_wstrb_zero();
        test_bready_stall();
        test_rready_stall();
        test_concurrent();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule
